seg7_scan_display: RTL
======================

// Module: seg7_scan_display
// PURPOSE
//  Display stage downstream of the 1 Hz divider/4-bit counter. Takes the counter value
//  (0-15), shows it in decimal on a 4-digit multiplexed 7-segment display
//  (common-anode, active-low) and scans the digits at a fixed refresh rate.
//  The input is produced in the divided-clock domain; this block re-times it into
//  clk with a 2-flop synchronizer plus a stability filter.
// PARAMETERS
//  REFRESH_DIV  100_000  clk cycles per digit slot (1 kHz at 100 MHz); legal range >= 2
//  CNT_W        17       width of refresh counter; must satisfy 2**CNT_W >= REFRESH_DIV
// PORTS
//  clk   in   1  system crystal clock, 100 MHz
//  rst   in   1  reset, asynchronous, active-high
//  val   in   4  binary value to display, asynchronous to clk
//  en    in   1  display enable, synchronous to clk; 0 blanks all digits
//  an    out  4  digit anodes, active-low one-hot; an[0] is the rightmost digit
//  seg   out  8  segments {dp,g,f,e,d,c,b,a}, active-low; dp always 1 (off)
// BEHAVIOUR
//  Reset (async, rst=1): rcnt=0, idx=0, s1=s2=s3=0, disp=0, an=4'hF, seg=8'hFF.
//  Synchronizer: every clk s1<=val, s2<=s1, s3<=s2. disp<=s2 only when s2==s3.
//   val stable -> disp updated 3 clk later. A value present in s2 for one clk only is
//   never loaded into disp.
//  Refresh counter: rcnt counts 0..REFRESH_DIV-1 and wraps to 0. tick=1 when
//   rcnt==REFRESH_DIV-1. On tick, idx advances 0->1->2->3->0 (2-bit wrap).
//  Digit contents: d0 = disp%10, d1 = disp/10 (0 or 1).
//   idx0 shows d0. idx1 shows d1, or blank if d1==0 (leading-zero suppression).
//   idx2 and idx3 are always blank (seg=8'hFF).
//  Outputs are registered and recomputed every clk from the current idx, disp and en:
//   en=1: an <= ~(4'b0001<<idx), seg <= font(digit) or 8'hFF when blank.
//   en=0: an <= 4'hF, seg <= 8'hFF. Scan and sync keep running while en=0.
//   Output latency: 1 clk after idx/disp/en changes. A disp change mid-slot shows
//   1 clk later; the slot is not restarted.
//  Font, active-low: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90.
//  Slot 0 starts on the first clk after reset release, with an=1110 one clk later.
//   Each slot lasts exactly REFRESH_DIV clk.
//  Reset mid-scan: all state returns to reset values immediately, regardless of clk.
//   The scan restarts at idx0 after release.
//  Arithmetic: rcnt is CNT_W bits unsigned. The d0/d1 split is combinational from the
//   4-bit disp (d1=1 iff disp>=10).
// TESTING (sim with REFRESH_DIV=4)
//  1 Reset: rst=1 -> an=F, seg=FF. Release -> an=E one clk later.
//    an=D exactly 4 clk after that, then B, 7, E.
//  2 Value 7: hold val=7 -> disp=7 after 3 clk.
//    idx0 seg=F8; idx1 seg=FF (leading zero blanked); idx2/3 seg=FF.
//  3 Value 13: val=13 -> idx0 seg=B0, idx1 seg=F9, idx2/3 seg=FF.
//    Value 10: idx0 seg=C0, idx1 seg=F9.
//  4 Glitch: disp=5, val pulses to 9 for exactly 1 clk aligned with s1 -> disp stays 5.
//    seg never shows 90.
//  5 Enable: en=0 during idx1 -> an=F, seg=FF next clk; idx still advances.
//    en=1 during idx3 -> an=7 next clk.
//  6 Reset mid-scan: assert rst while idx=2 between clk edges -> an=F, seg=FF at once.
//    After release, scan resumes from idx0 with disp=0 (seg=C0 on idx0).

Source files
------------

// File: rtl/seg7_scan_display_if.sv
// Display bus: value/enable in, digit anodes and segments out.
// master drives val/en and observes an/seg; slave is the display block.
interface seg7_scan_display_if;
   logic [3:0] val;
   logic       en;
   logic [3:0] an;
   logic [7:0] seg;

   modport master (
      output val,
      output en,
      input  an,
      input  seg
   );

   modport slave (
      input  val,
      input  en,
      output an,
      output seg
   );
endinterface

// File: rtl/seg7_scan_display.sv
// Shows a 4-bit value (0-15) in decimal on a 4-digit multiplexed 7-seg display.
// Ports: clk, rst (async, active-high), dsp.slave {val, en in; an, seg out active-low}.
module seg7_scan_display #(
   parameter int REFRESH_DIV = 100_000,
   parameter int CNT_W       = 17
) (
   input  logic                 clk,
   input  logic                 rst,
   seg7_scan_display_if.slave   dsp
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(REFRESH_DIV - 1);

   logic [CNT_W-1:0] rcnt;
   logic [1:0]       idx;
   logic [3:0]       s1, s2, s3;
   logic [3:0]       disp;
   logic             tick;
   logic             ge10;
   logic [3:0]       d0;
   logic [7:0]       seg_nxt;
   logic [3:0]       an_nxt;

   function automatic logic [7:0] font(input logic [3:0] d);
      logic [7:0] f;
      f = 8'hFF;
      unique case (d)
         4'd0: f = 8'hC0;
         4'd1: f = 8'hF9;
         4'd2: f = 8'hA4;
         4'd3: f = 8'hB0;
         4'd4: f = 8'h99;
         4'd5: f = 8'h92;
         4'd6: f = 8'h82;
         4'd7: f = 8'hF8;
         4'd8: f = 8'h80;
         4'd9: f = 8'h90;
         default: f = 8'hFF;
      endcase
      return f;
   endfunction

   assign tick = (rcnt == LAST);
   assign ge10 = (disp >= 4'd10);
   assign d0   = ge10 ? disp - 4'd10 : disp;

   // Tens digit is only ever 0 or 1; a 0 there is suppressed.
   always_comb begin
      an_nxt  = 4'hF;
      seg_nxt = 8'hFF;
      if (dsp.en) begin
         an_nxt = ~(4'b0001 << idx);
         unique case (1'b1)
            (idx == 2'd0):         seg_nxt = font(d0);
            (idx == 2'd1) && ge10: seg_nxt = font(4'd1);
            default:               seg_nxt = 8'hFF;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rcnt    <= '0;
         idx     <= '0;
         s1      <= '0;
         s2      <= '0;
         s3      <= '0;
         disp    <= '0;
         dsp.an  <= 4'hF;
         dsp.seg <= 8'hFF;
      end else begin
         rcnt <= tick ? '0 : rcnt + 1'b1;
         if (tick)
            idx <= idx + 2'd1;
         s1 <= dsp.val;
         s2 <= s1;
         s3 <= s2;
         // Load only a value seen on two consecutive clocks.
         if (s2 == s3)
            disp <= s2;
         dsp.an  <= an_nxt;
         dsp.seg <= seg_nxt;
      end
   end

endmodule
